// File: rtl/rf_param.sv
// Parameterised register file with two combinational read ports, one write
// port, a hardwired-zero entry 0 and a sequenced full-file clear. The clear
// walks every entry writing zero, one per clock, and runs after reset or on
// request via clear_i. While it runs, both read ports return zero and the
// write port is ignored.
module rf_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [AW-1:0]   addr_1_i,
    input  logic [AW-1:0]   addr_2_i,
    input  logic [AW-1:0]   addr_3_i,
    input  logic            WE3_i,
    input  logic [XLEN-1:0] WD3_i,
    input  logic            clear_i,
    output logic [XLEN-1:0] RD_1_o,
    output logic [XLEN-1:0] RD_2_o,
    output logic            busy_o
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_IDX = '0;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [AW-1:0]   clr_cnt_q;
    logic [AW-1:0]   clr_cnt_d;
    logic [XLEN-1:0] mem [NREGS];

    logic            in_idle;
    logic            wr_en;
    logic            clr_wr;
    logic            rd_block;

    // Select the value a read port presents: forced zero while the file is
    // unavailable or for entry 0, the in-flight write data on an address
    // match, otherwise the stored entry.
    function automatic logic [XLEN-1:0] read_sel(
        input logic            block,
        input logic [AW-1:0]   rd_addr,
        input logic            bypass_en,
        input logic [AW-1:0]   wr_addr,
        input logic [XLEN-1:0] wr_data,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] res;
        if (block || (rd_addr == ZERO_IDX)) begin
            res = '0;
        end else if (bypass_en && (rd_addr == wr_addr)) begin
            res = wr_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    assign in_idle  = (state_q == ST_IDLE);

    // A write lands only in IDLE, outside reset, when no clear is being
    // requested, and never to entry 0.
    assign wr_en    = !reset_i && in_idle && !clear_i && WE3_i
                      && (addr_3_i != ZERO_IDX);

    // The clear walk stalls at entry 0 while reset is held; the walk
    // proper starts on the first edge after release.
    assign clr_wr   = !reset_i && (state_q == ST_CLEAR);

    // Reads are blanked during the clear walk and while reset is asserted.
    assign rd_block = reset_i || (state_q == ST_CLEAR);

    assign busy_o   = (state_q == ST_CLEAR);

    // Next-state logic: IDLE -> CLEAR on request, CLEAR walks every entry
    // once and returns to IDLE; clear_i is ignored while walking.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State register: reset forces (and holds) the start of a fresh clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array: the clear walk has priority over the write port, which
    // is already disabled outside IDLE.
    always_ff @(posedge clk_i) begin
        if (clr_wr) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem[addr_3_i] <= WD3_i;
        end
    end

    // Read port 1 with write-through bypass.
    always_comb begin
        RD_1_o = read_sel(rd_block, addr_1_i, wr_en, addr_3_i, WD3_i,
                          mem[addr_1_i]);
    end

    // Read port 2 with write-through bypass.
    always_comb begin
        RD_2_o = read_sel(rd_block, addr_2_i, wr_en, addr_3_i, WD3_i,
                          mem[addr_2_i]);
    end

endmodule
